serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. It accepts two operands plus a borrow-in through a valid/ready handshake.
- Computes a - b - bin LSB-first, one bit per clock, through a single 1-bit full-subtractor cell and a borrow flip-flop.
- Presents the difference and borrow-out on a valid/ready result port.
- Serves as the arithmetic counterpart to the existing 1-bit full adder. Intended for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is 2..32.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands valid
- start_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend, sampled on start handshake
- b  input  WIDTH  subtrahend, sampled on start handshake
- bin  input  1  borrow-in, sampled on start handshake
- busy  output  1  high in SHIFT or DONE
- diff_valid  output  1  result valid
- diff_ready  input  1  consumer accepts result
- diff  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff unsigned a < b + bin

Behaviour:
- Reset (async assert, sync deassert by clk): state=IDLE, start_ready=1, busy=0, diff_valid=0, diff=0, bout=0, internal shift registers, borrow and bit counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready at edge T0: latch a, b into shift registers, load borrow FF with bin, clear counter, go to SHIFT.
- SHIFT:
  - Each cycle, the cell takes a_i=a_sr[0], b_i=b_sr[0] and br=borrow FF.
  - d_i = a_i^b_i^br.
  - br' = (~a_i&b_i) | (~(a_i^b_i)&br).
  - d_i shifts into result register MSB side (result right-shifts). a_sr and b_sr right-shift. Borrow FF <= br'. Counter increments.
  - After WIDTH SHIFT cycles, go to DONE.
- DONE:
  - diff_valid=1 from edge T0+WIDTH onward.
  - diff and bout (= final borrow FF) are held stable while diff_valid && !diff_ready.
  - On diff_valid&&diff_ready, go to IDLE next edge. diff_valid drops and start_ready rises in the same cycle.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH shifts ending in DONE, one handshake cycle). There is no accept/result overlap.
- Outside IDLE, start_valid is ignored (start_ready=0). Operands are not re-sampled.
- diff and bout retain their last values after the handshake until the next operation completes. Consumers use diff_valid only.
- diff_ready asserted outside DONE has no effect.
- Reset mid-operation (any state, any bit): immediate return to reset values. The partial result is discarded.
- Wrap-around: 0x00-0x01 gives 0xFF with bout=1. Borrow-in propagates through all WIDTH bits.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), valid alongside diff_valid, held with diff.
  - ovf = signed two's-complement overflow = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]), using the latched operand MSBs.
- Undefined: port absent, no extra flops.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - counter width function clog2(WIDTH+1)
- Sub-module full_subtractor_1b (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once. It mirrors the existing full adder cell's port style and is reusable elsewhere.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0; diff_valid rises exactly 8 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x05, b=0x03 -> diff=0x02, ovf=0.
- Backpressure: result valid, diff_ready low 5 cycles -> diff/bout stable, start_ready=0, start_valid pulses ignored. diff_ready high -> IDLE next cycle, start_ready=1.
- Reset asserted during SHIFT after 3 bits -> all outputs immediately at reset values. After release, a=0xAA, b=0x55 -> diff=0x55, bout=0.
- Back-to-back: start_valid held high with new operands each accept -> second accept occurs exactly WIDTH+2 cycles after the first with diff_ready=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   state_e    - FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   cnt_width  - width of the bit counter for a given operand width
// Optional build macro used by the block: SERIAL_SUB_OVF_EN
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter width: clog2(WIDTH+1).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Operand (start) and result (diff) handshakes of the serial subtractor.
//   start_valid/start_ready, a, b, bin : operand handshake
//   busy                               : block is in SHIFT or DONE
//   diff_valid/diff_ready, diff, bout  : result handshake
//   ovf                                : signed overflow (SERIAL_SUB_OVF_EN only)
// Modports: master (producer/consumer side), slave (the subtractor).
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             diff_valid;
  logic             diff_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start_valid, a, b, bin, diff_ready,
    input  start_ready, busy, diff_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start_valid, a, b, bin, diff_ready,
    output start_ready, busy, diff_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/full_subtractor_1b.sv
// -----------------------------------------------------------------------------
// full_subtractor_1b
// Purely combinational 1-bit full subtractor: d = a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
// -----------------------------------------------------------------------------
module full_subtractor_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing a - b - bin LSB-first, one bit per
// clock, through a single full_subtractor_1b cell and a borrow flip-flop.
// Latency: diff_valid rises WIDTH cycles after the operand accept edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_subtractor_if.slave (operand and result handshakes)
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output bus.ovf.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  // a_sr doubles as the result register: difference bits enter at the MSB
  // while minuend bits leave at the LSB, so after WIDTH shifts it holds diff.
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Separate output registers keep diff/bout stable from completion until the
  // next operation completes, even while the shift registers are reused.
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bout;

  full_subtractor_1b u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end
      end

      ST_SHIFT: begin
        a_sr_d = {cell_d, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        br_d   = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Last bit: capture the finished result straight from the cell so
          // diff is already complete on the edge that enters DONE.
          state_d = ST_DONE;
          diff_d  = {cell_d, a_sr_q[WIDTH-1:1]};
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
          // cell_d is the difference MSB on the final bit.
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end

      ST_DONE: begin
        if (bus.diff_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.diff_valid  = (state_q == ST_DONE);
  assign bus.diff        = diff_q;
  assign bus.bout        = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8): table-driven operand
// vectors plus hand-written sequences for backpressure, mid-operation reset
// and back-to-back throughput. Define SERIAL_SUB_OVF_EN to also check ovf.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for diff_valid; returns the number of edges waited.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.diff_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.a           = a;
    bus.b           = b;
    bus.bin         = bin;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
  endtask

  task automatic do_op(input string name, input vec_t v);
    int cyc;
    check({name, " start_ready"}, 32'(bus.start_ready), 32'd1);
    accept(v.a, v.b, v.bin);
    wait_valid(cyc);
    check({name, " latency"}, 32'(cyc), 32'(W));
    check({name, " diff"}, 32'(bus.diff), 32'(v.d));
    check({name, " bout"}, 32'(bus.bout), 32'(v.bo));
`ifdef SERIAL_SUB_OVF_EN
    check({name, " ovf"}, 32'(bus.ovf), 32'(v.ov));
`endif
    bus.diff_ready = 1'b1;
    tick();
    bus.diff_ready = 1'b0;
    check({name, " valid drop"}, 32'(bus.diff_valid), 32'd0);
    check({name, " ready rise"}, 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    int acc_t[2];

    //           a      b      bin   diff   bout  ovf
    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0};
    vecs[9] = '{8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 1'b0};

    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.bin         = 1'b0;
    bus.diff_ready  = 1'b0;

    // Reset state.
    #3;
    check("rst start_ready", 32'(bus.start_ready), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst diff_valid", 32'(bus.diff_valid), 32'd0);
    check("rst diff", 32'(bus.diff), 32'd0);
    check("rst bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // diff_ready outside DONE has no effect.
    bus.diff_ready = 1'b1;
    tick();
    bus.diff_ready = 1'b0;
    check("idle ready ignored", 32'({bus.start_ready, bus.busy, bus.diff_valid}), 32'b100);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held 5 cycles, start pulses ignored.
    accept(8'h35, 8'h12, 1'b0);
    wait_valid(cyc);
    check("bp latency", 32'(cyc), 32'(W));
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = i[0];
      bus.a           = 8'hFF;
      bus.b           = 8'h00;
      check($sformatf("bp%0d diff", i), 32'(bus.diff), 32'h23);
      check($sformatf("bp%0d bout", i), 32'(bus.bout), 32'd0);
      check($sformatf("bp%0d valid", i), 32'(bus.diff_valid), 32'd1);
      check($sformatf("bp%0d start_ready", i), 32'(bus.start_ready), 32'd0);
      tick();
    end
    bus.start_valid = 1'b0;
    bus.diff_ready  = 1'b1;
    tick();
    bus.diff_ready  = 1'b0;
    check("bp release valid", 32'(bus.diff_valid), 32'd0);
    check("bp release start_ready", 32'(bus.start_ready), 32'd1);
    check("bp diff retained", 32'(bus.diff), 32'h23);
    tick();
    check("bp no spurious start", 32'(bus.busy), 32'd0);

    // Reset during SHIFT after 3 bits.
    accept(8'h35, 8'h12, 1'b0);
    tick();
    tick();
    tick();
    check("mid busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst start_ready", 32'(bus.start_ready), 32'd1);
    check("mid rst busy", 32'(bus.busy), 32'd0);
    check("mid rst valid", 32'(bus.diff_valid), 32'd0);
    check("mid rst diff", 32'(bus.diff), 32'd0);
    check("mid rst bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op("post rst", '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1});

    // Back-to-back with start_valid held and diff_ready high.
    bus.a           = 8'h35;
    bus.b           = 8'h12;
    bus.bin         = 1'b0;
    bus.start_valid = 1'b1;
    bus.diff_ready  = 1'b1;
    n = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      if (bus.diff_valid) begin
        check("b2b first diff", 32'(bus.diff), 32'h23);
      end
      if (bus.start_ready) begin
        acc_t[n] = i;
        n++;
      end
      tick();
      if (n == 1) begin
        bus.a = 8'h80;
        bus.b = 8'h01;
      end
    end
    bus.start_valid = 1'b0;
    check("b2b accepts", 32'(n), 32'd2);
    check("b2b spacing", 32'(acc_t[1] - acc_t[0]), 32'(W + 2));
    wait_valid(cyc);
    check("b2b second latency", 32'(cyc), 32'(W));
    check("b2b second diff", 32'(bus.diff), 32'h7F);
    check("b2b second bout", 32'(bus.bout), 32'd0);
    tick();
    bus.diff_ready = 1'b0;
    check("b2b end idle", 32'(bus.start_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
